ed25519_frame_loader: RTL



---
 rtl/ed25519_pkg.sv | 30 +++
 rtl/ed25519_limb_sub.sv | 19 +
 rtl/ed25519_frame_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ed25519_pkg.sv
// Shared constants and types for the ed25519 frame loader: field modulus limbs,
// frame layout and the loader state encoding.
package ed25519_pkg;

  localparam int WORD_W          = 64;
  localparam int WORDS_PER_FIELD = 4;
  localparam int FIELDS          = 3;
  localparam int FRAME_WORDS     = WORDS_PER_FIELD * FIELDS;

  localparam int M_BASE  = 0;
  localparam int XP_BASE = 4;
  localparam int YP_BASE = 8;

  typedef logic [WORD_W-1:0] word_t;

  // Q = 2^255 - 19, least-significant limb first.
  localparam word_t Q_LIMB [0:3] = '{
    64'hFFFF_FFFF_FFFF_FFED,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'h7FFF_FFFF_FFFF_FFFF
  };

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REDUCE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/ed25519_limb_sub.sv
// One 64-bit limb of a multi-precision subtract: diff = a - b - bin, with borrow out.
module ed25519_limb_sub
  import ed25519_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  logic  i_bin,
  output word_t o_diff,
  output logic  o_bout
);

  logic [WORD_W:0] full;

  // The extra top bit becomes 1 exactly when a < b + bin.
  assign full   = {1'b0, i_a} - {1'b0, i_b} - {{WORD_W{1'b0}}, i_bin};
  assign o_diff = full[WORD_W-1:0];
  assign o_bout = full[WORD_W];

endmodule

// File: rtl/ed25519_frame_loader.sv
// Buffers one 12-word job frame, canonicalises xp/yp mod 2^255-19 with a single
// limb-serial conditional subtract, then replays the frame to the scalar-mult core.
module ed25519_frame_loader
  import ed25519_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_data,
  output logic [1:0]  o_reduced,
  output logic        o_busy
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  r_q, r_d;
  logic        borrow_q, borrow_d;
  logic [1:0]  reduced_q, reduced_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  word_t       temp_q [0:2];
  word_t       temp_d [0:2];
  word_t       buf_q  [0:FRAME_WORDS-1];
  word_t       buf_d  [0:FRAME_WORDS-1];

  logic        in_hs, out_hs;
  logic [3:0]  limb_base, limb_idx;
  word_t       sub_diff;
  logic        sub_bin, sub_bout;

  assign o_in_ready  = (state_q == FILL);
  assign o_out_valid = out_valid_q;
  assign o_out_data  = buf_q[idx_q];
  assign o_reduced   = reduced_q;
  assign o_busy      = busy_q;

  assign in_hs  = i_in_valid && o_in_ready;
  assign out_hs = out_valid_q && i_out_ready;

  // r[2] picks the field (xp then yp), r[1:0] walks its limbs LSB first.
  assign limb_base = r_q[2] ? 4'(YP_BASE) : 4'(XP_BASE);
  assign limb_idx  = limb_base + 4'd3 - {2'b00, r_q[1:0]};
  assign sub_bin   = (r_q[1:0] == 2'd0) ? 1'b0 : borrow_q;

  ed25519_limb_sub u_limb_sub (
    .i_a    (buf_q[limb_idx]),
    .i_b    (Q_LIMB[r_q[1:0]]),
    .i_bin  (sub_bin),
    .o_diff (sub_diff),
    .o_bout (sub_bout)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    r_d       = r_q;
    borrow_d  = borrow_q;
    reduced_d = reduced_q;
    temp_d    = temp_q;
    buf_d     = buf_q;

    unique case (state_q)
      FILL: begin
        if (in_hs) begin
          // Word 0 of every field is its MSB word; bit 255 is not part of the value.
          buf_d[idx_q] = (idx_q[1:0] == 2'd0) ? {1'b0, i_in_data[62:0]} : i_in_data;
          if (idx_q == 4'd0) reduced_d = 2'b00;
          if (idx_q == 4'(FRAME_WORDS - 1)) begin
            idx_d   = 4'd0;
            r_d     = 3'd0;
            state_d = REDUCE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      REDUCE: begin
        borrow_d = sub_bout;
        unique case (r_q[1:0])
          2'd0: temp_d[0] = sub_diff;
          2'd1: temp_d[1] = sub_diff;
          2'd2: temp_d[2] = sub_diff;
          2'd3: begin
            // No final borrow means value >= Q: commit value - Q. Since value < 2Q, once is enough.
            if (!sub_bout) begin
              buf_d[limb_base]        = sub_diff;
              buf_d[limb_base + 4'd1] = temp_q[2];
              buf_d[limb_base + 4'd2] = temp_q[1];
              buf_d[limb_base + 4'd3] = temp_q[0];
              reduced_d[r_q[2]]       = 1'b1;
            end
          end
          default: ;
        endcase
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) state_d = DRAIN;
      end

      DRAIN: begin
        if (out_hs) begin
          if (idx_q == 4'(FRAME_WORDS - 1)) begin
            idx_d   = 4'd0;
            state_d = FILL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign out_valid_d = (state_d == DRAIN);
  assign busy_d      = (state_d != FILL);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= FILL;
      idx_q       <= 4'd0;
      r_q         <= 3'd0;
      borrow_q    <= 1'b0;
      reduced_q   <= 2'b00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      r_q         <= r_d;
      borrow_q    <= borrow_d;
      reduced_q   <= reduced_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: frame storage has no reset; every word is written in FILL before it can be read.
  always_ff @(posedge i_clk) begin
    temp_q <= temp_d;
    buf_q  <= buf_d;
  end

endmodule
